// File: rtl/xmodem_pkg.sv
// XMODEM sender shared definitions.
// Protocol byte codes and the sequencer state type.
package xmodem_pkg;

  localparam logic [7:0] SOH     = 8'h01;
  localparam logic [7:0] EOT     = 8'h04;
  localparam logic [7:0] ACK     = 8'h06;
  localparam logic [7:0] NAK     = 8'h15;
  localparam logic [7:0] CAN     = 8'h18;
  localparam logic [7:0] ASCII_C = 8'h43;

  localparam int unsigned BLOCK_BYTES = 128;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT_START,
    S_SEND_PKT,
    S_WAIT_PKT,
    S_WAIT_RESP,
    S_SEND_EOT,
    S_WAIT_EOT,
    S_SEND_CAN,
    S_DONE,
    S_ABORT_ERR
  } xmodem_seq_state_t;

endpackage

// File: rtl/xmodem_resp_timer.sv
// Response wait timer: cleared on wait entry, counts while enabled.
// Timeout holds from TIMEOUT_CYCLES-1 onward so a late rearm still expires.
module xmodem_resp_timer
  import xmodem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20,
  parameter int unsigned TIMER_W        = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam logic [TIMER_W-1:0] LAST =
    TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = en && (cnt_q >= LAST);

endmodule

// File: rtl/xmodem_tx_sequencer.sv
// XMODEM checksum sender controller: start wait, block loop with
// ACK/NAK/timeout retries, EOT handshake and CAN abort.
module xmodem_tx_sequencer
  import xmodem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20,
  parameter int unsigned MAX_RETRIES    = 10,
  parameter int unsigned TIMER_W        = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send_data,
  input  logic [7:0] data_length,
  output logic [7:0] data_addr,
  output logic [7:0] blk_num,
  output logic       msg_send,
  input  logic       msg_sent,
  output logic       ctl_valid,
  output logic [7:0] ctl_byte,
  input  logic       ctl_ready,
  output logic       resp_req,
  input  logic [7:0] resp_data,
  input  logic       resp_valid,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
  localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRIES);

  xmodem_seq_state_t state_q, state_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        addr_q, addr_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic              msg_send_q, msg_send_d;
  logic              ctl_valid_q, ctl_valid_d;
  logic [7:0]        ctl_byte_q, ctl_byte_d;
  logic              resp_req_q, resp_req_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              busy_q, busy_d;

  logic tmr_clr, tmr_en, tmo;
  logic rx_ack, rx_nak, rx_c, rx_can;
  logic retry_max, ctl_xfer;
  logic [7:0] addr_inc;

  assign rx_ack    = resp_valid && (resp_data == ACK);
  assign rx_nak    = resp_valid && (resp_data == NAK);
  assign rx_c      = resp_valid && (resp_data == ASCII_C);
  assign rx_can    = resp_valid && (resp_data == CAN);
  assign retry_max = (retry_q == MAX_R);
  assign ctl_xfer  = ctl_valid_q && ctl_ready;
  assign addr_inc  = addr_q + 8'd1;

  assign tmr_en = (state_q == S_WAIT_START) ||
                  (state_q == S_WAIT_RESP)  ||
                  (state_q == S_WAIT_EOT);

  xmodem_resp_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMER_W       (TIMER_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .timeout(tmo)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_d      = addr_q;
    retry_d     = retry_q;
    msg_send_d  = 1'b0;
    ctl_valid_d = ctl_valid_q;
    ctl_byte_d  = ctl_byte_q;
    resp_req_d  = 1'b0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    tmr_clr     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (send_data) begin
          len_d      = data_length;
          addr_d     = 8'd0;
          retry_d    = '0;
          state_d    = S_WAIT_START;
          resp_req_d = 1'b1;
          tmr_clr    = 1'b1;
        end
      end
      S_WAIT_START: begin
        if (rx_c || rx_nak) begin
          retry_d = '0;
          if (len_q == 8'd0) begin
            state_d     = S_SEND_EOT;
            ctl_valid_d = 1'b1;
            ctl_byte_d  = EOT;
          end else begin
            state_d    = S_SEND_PKT;
            msg_send_d = 1'b1;
          end
        end else if (rx_can) begin
          state_d = S_ABORT_ERR;
          error_d = 1'b1;
        end else if (resp_valid) begin
          resp_req_d = 1'b1;
        end else if (tmo) begin
          if (retry_max) begin
            state_d     = S_SEND_CAN;
            ctl_valid_d = 1'b1;
            ctl_byte_d  = CAN;
          end else begin
            retry_d    = retry_q + RW'(1);
            resp_req_d = 1'b1;
            tmr_clr    = 1'b1;
          end
        end
      end
      S_SEND_PKT: begin
        state_d = S_WAIT_PKT;
      end
      S_WAIT_PKT: begin
        if (msg_sent) begin
          state_d    = S_WAIT_RESP;
          resp_req_d = 1'b1;
          tmr_clr    = 1'b1;
        end
      end
      S_WAIT_RESP: begin
        if (rx_ack) begin
          retry_d = '0;
          addr_d  = addr_inc;
          if (addr_inc == len_q) begin
            state_d     = S_SEND_EOT;
            ctl_valid_d = 1'b1;
            ctl_byte_d  = EOT;
          end else begin
            state_d    = S_SEND_PKT;
            msg_send_d = 1'b1;
          end
        end else if (rx_nak || (!resp_valid && tmo)) begin
          if (retry_max) begin
            state_d     = S_SEND_CAN;
            ctl_valid_d = 1'b1;
            ctl_byte_d  = CAN;
          end else begin
            retry_d    = retry_q + RW'(1);
            state_d    = S_SEND_PKT;
            msg_send_d = 1'b1;
          end
        end else if (rx_can) begin
          state_d = S_ABORT_ERR;
          error_d = 1'b1;
        end else if (resp_valid) begin
          resp_req_d = 1'b1;
        end
      end
      S_SEND_EOT: begin
        if (ctl_xfer) begin
          ctl_valid_d = 1'b0;
          state_d     = S_WAIT_EOT;
          resp_req_d  = 1'b1;
          tmr_clr     = 1'b1;
        end
      end
      S_WAIT_EOT: begin
        if (rx_ack) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (rx_nak || (!resp_valid && tmo)) begin
          ctl_valid_d = 1'b1;
          if (retry_max) begin
            state_d    = S_SEND_CAN;
            ctl_byte_d = CAN;
          end else begin
            retry_d    = retry_q + RW'(1);
            state_d    = S_SEND_EOT;
            ctl_byte_d = EOT;
          end
        end else if (rx_can) begin
          state_d = S_ABORT_ERR;
          error_d = 1'b1;
        end else if (resp_valid) begin
          resp_req_d = 1'b1;
        end
      end
      S_SEND_CAN: begin
        if (ctl_xfer) begin
          ctl_valid_d = 1'b0;
          state_d     = S_ABORT_ERR;
          error_d     = 1'b1;
        end
      end
      S_DONE:      state_d = S_IDLE;
      S_ABORT_ERR: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= 8'd0;
      addr_q      <= 8'd0;
      retry_q     <= '0;
      msg_send_q  <= 1'b0;
      ctl_valid_q <= 1'b0;
      ctl_byte_q  <= 8'h00;
      resp_req_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      retry_q     <= retry_d;
      msg_send_q  <= msg_send_d;
      ctl_valid_q <= ctl_valid_d;
      ctl_byte_q  <= ctl_byte_d;
      resp_req_q  <= resp_req_d;
      done_q      <= done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  assign data_addr = addr_q;
  assign blk_num   = addr_q + 8'd1;
  assign msg_send  = msg_send_q;
  assign ctl_valid = ctl_valid_q;
  assign ctl_byte  = ctl_byte_q;
  assign resp_req  = resp_req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule
